i2c_write_master: RTL and testbench

Single-clock I2C write engine that consumes the 24-bit `{slave_addr, sub_addr, data}` word and GO request from the HDMI configuration sequencer and emits one complete I2C write transaction on SCL/SDA. It drives START, three bytes MSB-first with ACK slots, and STOP, then reports END and the aggregated ACK status. It sits between the configuration sequencer and the HDMI transmitter pins.

---
 rtl/i2c_write_master.sv | 146 ++++++++++++++
 tb/tb_i2c_write_master.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_master.sv
// i2c_write_master: one I2C write (START, 3 bytes + ACK slots, STOP) per GO/END level handshake.
// Optional I2C_SDA_FILTER_EN adds a 3-sample majority filter after the SDA synchronizer.
module i2c_write_master #(
    parameter int CLK_Freq = 50000000,
    parameter int I2C_Freq = 20000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [23:0] I2C_DATA,
    input  logic        GO,
    output logic        END,
    output logic        ACK,
    output logic        I2C_SCLK,
    inout  wire         I2C_SDAT
);
    localparam int DIV = CLK_Freq / (4 * I2C_Freq);
    localparam int DW  = $clog2(DIV);

    typedef enum logic [2:0] {IDLE, START, BIT, ACKSLOT, STOP, DONE} state_t;

    state_t        state, state_n;
    logic [DW-1:0] div;
    logic [1:0]    q, q_n;
    logic [2:0]    nbit, nbit_n;
    logic [1:0]    nbyte, nbyte_n;
    logic [23:0]   sh, sh_n;
    logic          nack, nack_n;
    logic          end_flag, end_n;
    logic          scl, scl_n;
    logic          sda_oe, oe_n;
    logic [1:0]    sync;
    logic          sda_in;
    logic          busy, tick;

    assign busy     = state inside {START, BIT, ACKSLOT, STOP};
    assign tick     = busy && div == DW'(DIV - 1);
    assign I2C_SDAT = sda_oe ? 1'b0 : 1'bz;
    assign I2C_SCLK = scl;
    assign END      = end_flag;
    assign ACK      = nack;

`ifdef I2C_SDA_FILTER_EN
    logic [2:0] hist;
    logic       flt;
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hist <= 3'b111;
            flt  <= 1'b1;
        end else begin
            hist <= {hist[1:0], sync[1]};
            flt  <= (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
        end
    end
    assign sda_in = flt;
`else
    assign sda_in = sync[1];
`endif

    always_comb begin
        state_n = state;
        q_n     = q;
        nbit_n  = nbit;
        nbyte_n = nbyte;
        sh_n    = sh;
        nack_n  = nack;
        end_n   = end_flag;
        if (tick)
            q_n = 2'(q + 2'd1);
        case (state)
            IDLE: if (GO && !end_flag) begin
                state_n = START;
                q_n     = '0;
                nbit_n  = '0;
                nbyte_n = '0;
                sh_n    = I2C_DATA;
                nack_n  = 1'b0;
            end
            START: if (tick && q == 2'd3) state_n = BIT;
            BIT: if (tick && q == 2'd3) begin
                sh_n   = {sh[22:0], 1'b0};
                nbit_n = 3'(nbit + 3'd1);
                if (nbit == 3'd7) state_n = ACKSLOT;
            end
            ACKSLOT: begin
                if (tick && q == 2'd2 && sda_in) nack_n = 1'b1;
                if (tick && q == 2'd3) begin
                    nbyte_n = 2'(nbyte + 2'd1);
                    state_n = (nbyte == 2'd2) ? STOP : BIT;
                end
            end
            STOP: if (tick && q == 2'd3) state_n = DONE;
            DONE: begin
                // END rises one edge after entering DONE and drops on the edge that sees GO low
                end_n = !(end_flag && !GO);
                if (end_flag && !GO) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        scl_n = 1'b1;
        oe_n  = 1'b0;
        case (state_n)
            START: begin
                scl_n = !q_n[1];
                oe_n  = q_n != 2'd0;
            end
            BIT: begin
                scl_n = q_n[0] ^ q_n[1];
                oe_n  = !sh_n[23];
            end
            ACKSLOT: scl_n = q_n[0] ^ q_n[1];
            STOP: begin
                scl_n = q_n != 2'd0;
                oe_n  = !q_n[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= IDLE;
            div      <= '0;
            q        <= '0;
            nbit     <= '0;
            nbyte    <= '0;
            sh       <= '0;
            nack     <= 1'b0;
            end_flag <= 1'b0;
            scl      <= 1'b1;
            sda_oe   <= 1'b0;
            sync     <= 2'b11;
        end else begin
            state    <= state_n;
            div      <= (!busy || tick) ? '0 : DW'(div + 1'b1);
            q        <= q_n;
            nbit     <= nbit_n;
            nbyte    <= nbyte_n;
            sh       <= sh_n;
            nack     <= nack_n;
            end_flag <= end_n;
            scl      <= scl_n;
            sda_oe   <= oe_n;
            sync     <= {sync[0], I2C_SDAT};
        end
    end
endmodule

// File: tb/tb_i2c_write_master.sv
// tb_i2c_write_master: table-driven transfers against a bus-decoding slave model, plus reset and GO-pulse sequences.
module tb_i2c_write_master;
    localparam int DIV   = 4;
    localparam int LAT   = 116 * DIV + 2;
    localparam int LIMIT = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] data = '0;
    logic        go = 1'b0;
    logic        done, ack, scl;
    logic        slave_low = 1'b0;
    wire         sda;

    int checks = 0;
    int failures = 0;

    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    i2c_write_master #(.CLK_Freq(80), .I2C_Freq(5)) dut (
        .iCLK(clk), .iRST_N(rst_n), .I2C_DATA(data), .GO(go),
        .END(done), .ACK(ack), .I2C_SCLK(scl), .I2C_SDAT(sda)
    );

    always #5 clk = ~clk;

    initial begin
        repeat (40000) @(posedge clk);
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic run_xfer(input string tag, input logic [23:0] d, input logic [2:0] nack_m,
                            input logic [2:0] glitch_m, input int hold, input logic exp_ack);
        logic [23:0] got;
        logic start_ok, stop_ok;
        int n;
        go = 1'b1;
        data = d;
        fork
            begin
                @(negedge sda);
                start_ok = scl;
                for (int b = 0; b < 3; b++) begin
                    for (int i = 0; i < 8; i++) begin
                        @(posedge scl);
                        got = {got[22:0], sda};
                    end
                    @(negedge scl);
                    #1 slave_low = !nack_m[2-b];
                    @(posedge scl);
                    if (glitch_m[2-b]) begin
                        repeat (2 * DIV - 3) @(posedge clk);
                        #1 slave_low = 1'b0;
                        @(posedge clk);
                        #1 slave_low = 1'b1;
                    end
                    @(negedge scl);
                    #1 slave_low = 1'b0;
                end
                @(posedge scl);
                @(posedge sda);
                stop_ok = scl;
            end
            begin
                @(posedge clk);
                #1 data = ~d;
                n = 1;
                while (!done && n < LIMIT) begin
                    @(posedge clk);
                    #1 n++;
                end
            end
        join
        chk({tag, "_start"}, 32'(start_ok), 32'd1);
        chk({tag, "_bytes"}, 32'(got), 32'(d));
        chk({tag, "_stop"}, 32'(stop_ok), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'(LAT));
        chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            chk({tag, "_hold_end"}, 32'(done), 32'd1);
            chk({tag, "_hold_sda"}, 32'(sda), 32'd1);
        end
        go = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_end_clr"}, 32'(done), 32'd0);
        chk({tag, "_idle_scl"}, 32'(scl), 32'd1);
        chk({tag, "_idle_sda"}, 32'(sda), 32'd1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [23:0] d;
        logic [2:0]  nack_m;
        logic [2:0]  glitch_m;
        int          hold;
        logic        exp_ack;
    } vec_t;

    vec_t vt[5];
    int n, w;

    initial begin
        vt[0] = '{24'h729803, 3'b000, 3'b000, 0, 1'b0};
        vt[1] = '{24'h720100, 3'b010, 3'b000, 0, 1'b1};
        vt[2] = '{24'h729803, 3'b000, 3'b000, 30, 1'b0};
        vt[3] = '{24'h72AF16, 3'b000, 3'b000, 0, 1'b0};
        vt[4] = '{24'h729803, 3'b000, 3'b100, 0,
`ifdef I2C_SDA_FILTER_EN
                  1'b0
`else
                  1'b1
`endif
                 };

        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", 32'(scl), 32'd1);
        chk("rst_sda", 32'(sda), 32'd1);
        chk("rst_end", 32'(done), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_scl", 32'(scl), 32'd1);
        chk("idle_end", 32'(done), 32'd0);

        for (int i = 0; i < 5; i++)
            run_xfer($sformatf("v%0d", i), vt[i].d, vt[i].nack_m, vt[i].glitch_m, vt[i].hold, vt[i].exp_ack);

        // one-cycle GO pulse: transfer still completes, END lasts exactly one cycle
        data = 24'h729803;
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        n = 1;
        while (!done && n < LIMIT) begin
            @(posedge clk);
            #1 n++;
        end
        chk("pulse_latency", 32'(n), 32'(LAT));
        chk("pulse_ack", 32'(ack), 32'd1);
        w = 0;
        while (done && w < 10) begin
            @(posedge clk);
            #1 w++;
        end
        chk("pulse_end_width", 32'(w), 32'd1);
        @(posedge clk);
        #1;

        // asynchronous reset at tick 40 while byte 1 MSB (0) is being driven
        data = 24'h720100;
        go = 1'b1;
        repeat (1 + 40 * DIV) @(posedge clk);
        #1;
        chk("mid_scl_pre", 32'(scl), 32'd0);
        chk("mid_sda_pre", 32'(sda), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_scl", 32'(scl), 32'd1);
        chk("mid_rst_sda", 32'(sda), 32'd1);
        chk("mid_rst_end", 32'(done), 32'd0);
        chk("mid_rst_ack", 32'(ack), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run_xfer("post_rst", 24'h729803, 3'b000, 3'b000, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
